// File: rtl/msx_slot_expander.sv
// MSX primary/secondary slot selector: holds the A8h primary slot register and
// per-slot FFFFh subslot registers, and decodes slot, subslot and page selects.
module msx_slot_expander #(
  parameter logic [3:0] EXPANDED   = 4'b1000,
  parameter logic [7:0] PSLOT_PORT = 8'hA8,
  parameter bit         BOOT_GATE  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  input  logic        iorq_n,
  input  logic        mreq_n,
  input  logic        rfrsh_n,
  input  logic        rd_n,
  input  logic        wr_n,
  output logic [7:0]  dout,
  output logic        dout_oe,
  output logic [7:0]  pslot_q,
  output logic [3:0]  sltsl_n,
  output logic [15:0] exp_sltsl_n,
  output logic        cs1_n,
  output logic        cs2_n,
  output logic        cs01_n,
  output logic        cs12_n
);

  logic [7:0] pslot_r;
  logic [7:0] sub_r [4];
  logic       enable_r;
  logic       iowr_d_r;
  logic       memwr_d_r;

  logic       iowr_s;
  logic       selmem_s;
  logic       memwr_s;
  logic       top_s;
  logic [1:0] page_s;
  logic [1:0] p3_s;
  logic       p3_exp_s;
  logic [1:0] ps_s;
  logic [1:0] ss_s;
  logic       owned_s;
  logic       cs0_s;

  // Selects the 2-bit slot field belonging to a 16K page.
  function automatic logic [1:0] page_field(input logic [7:0] v, input logic [1:0] pg);
    logic [1:0] f;
    case (pg)
      2'd0:    f = v[1:0];
      2'd1:    f = v[3:2];
      2'd2:    f = v[5:4];
      2'd3:    f = v[7:6];
      default: f = 2'd0;
    endcase
    return f;
  endfunction

  // Bus strobes and page/slot decode
  always_comb begin
    iowr_s   = ~iorq_n & ~wr_n & (addr[7:0] == PSLOT_PORT);
    selmem_s = ~mreq_n & rfrsh_n;
    top_s    = (addr == 16'hFFFF);
    memwr_s  = selmem_s & ~wr_n & top_s;
    page_s   = addr[15:14];
    p3_s     = pslot_r[7:6];
    p3_exp_s = EXPANDED[p3_s];
    if (BOOT_GATE && !enable_r) begin
      ps_s = 2'd0;
    end else begin
      ps_s = page_field(pslot_r, page_s);
    end
    if (EXPANDED[ps_s]) begin
      ss_s = page_field(sub_r[ps_s], page_s);
    end else begin
      ss_s = 2'd0;
    end
    // An FFFFh access on an expanded page-3 slot belongs to the expander itself.
    owned_s = top_s & p3_exp_s;
  end

  // Slot/subslot selects, readback and page chip-selects
  always_comb begin
    sltsl_n     = 4'hF;
    exp_sltsl_n = 16'hFFFF;
    if (selmem_s && !owned_s) begin
      sltsl_n[ps_s]            = 1'b0;
      exp_sltsl_n[{ps_s, ss_s}] = 1'b0;
    end else begin
      sltsl_n     = 4'hF;
      exp_sltsl_n = 16'hFFFF;
    end
    if (top_s && selmem_s && !rd_n && p3_exp_s) begin
      dout    = ~sub_r[p3_s];
      dout_oe = 1'b1;
    end else begin
      dout    = 8'h00;
      dout_oe = 1'b0;
    end
    cs0_s  = ~((page_s == 2'd0) & ~rd_n);
    cs1_n  = ~((page_s == 2'd1) & ~rd_n);
    cs2_n  = ~((page_s == 2'd2) & ~rd_n);
    cs01_n = cs0_s & cs1_n;
    cs12_n = cs1_n & cs2_n;
    pslot_q = pslot_r;
  end

  // Edge-qualified register writes: one update per bus cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pslot_r   <= 8'h00;
      sub_r[0]  <= 8'h00;
      sub_r[1]  <= 8'h00;
      sub_r[2]  <= 8'h00;
      sub_r[3]  <= 8'h00;
      enable_r  <= 1'b0;
      iowr_d_r  <= 1'b0;
      memwr_d_r <= 1'b0;
    end else begin
      iowr_d_r  <= iowr_s;
      memwr_d_r <= memwr_s;
      if (iowr_s && !iowr_d_r) begin
        pslot_r  <= din;
        enable_r <= 1'b1;
      end
      // Indexed by the pre-update pslot even if A8h is written in the same cycle.
      if (memwr_s && !memwr_d_r && p3_exp_s) begin
        sub_r[p3_s] <= din;
      end
    end
  end

endmodule

// File: tb/tb_msx_slot_expander.sv
// Self-checking bench for msx_slot_expander: directed vector table, reset-mid-write
// sequence, and randomized bus traffic against a behavioural slot model.
module tb_msx_slot_expander;

  localparam logic [3:0] EXP  = 4'b1000;
  localparam logic [4:0] IDLE = 5'b11111; // {iorq_n, mreq_n, rfrsh_n, rd_n, wr_n}
  localparam logic [4:0] MRD  = 5'b10101;
  localparam logic [4:0] MWR  = 5'b10110;
  localparam logic [4:0] IOW  = 5'b01110;
  localparam logic [4:0] RFSH = 5'b10011;
  localparam int NV = 30;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        iorq_n, mreq_n, rfrsh_n, rd_n, wr_n;
  logic [7:0]  dout;
  logic        dout_oe;
  logic [7:0]  pslot_q;
  logic [3:0]  sltsl_n;
  logic [15:0] exp_sltsl_n;
  logic        cs1_n, cs2_n, cs01_n, cs12_n;

  int checks = 0;
  int errors = 0;

  msx_slot_expander dut (
    .clk(clk), .reset(reset), .addr(addr), .din(din),
    .iorq_n(iorq_n), .mreq_n(mreq_n), .rfrsh_n(rfrsh_n), .rd_n(rd_n), .wr_n(wr_n),
    .dout(dout), .dout_oe(dout_oe), .pslot_q(pslot_q),
    .sltsl_n(sltsl_n), .exp_sltsl_n(exp_sltsl_n),
    .cs1_n(cs1_n), .cs2_n(cs2_n), .cs01_n(cs01_n), .cs12_n(cs12_n)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {sltsl, exp_sltsl, {cs1,cs2,cs01,cs12}, oe, dout, pslot_q}
  logic [40:0] obs;
  assign obs = {sltsl_n, exp_sltsl_n, cs1_n, cs2_n, cs01_n, cs12_n, dout_oe, dout, pslot_q};

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic [4:0]  c;
    logic [40:0] e;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic [15:0] a, input logic [7:0] d, input logic [4:0] c,
                              input logic [3:0] sl, input logic [15:0] ex, input logic [3:0] cs,
                              input logic oe, input logic [7:0] dq, input logic [7:0] pq);
    vec_t v;
    v.a = a; v.d = d; v.c = c;
    v.e = {sl, ex, cs, oe, dq, pq};
    return v;
  endfunction

  // Behavioural model state
  logic [7:0] m_pslot;
  logic [7:0] m_sub [4];
  logic       m_en, m_pio, m_pmem;

  function automatic logic [40:0] model_out();
    int page, ps, ss, p3;
    logic sm, owned;
    logic [3:0] sl;
    logic [15:0] ex;
    logic oe;
    logic [7:0] dq;
    logic [3:0] cs;
    page  = int'(addr) / 16384;
    p3    = int'(m_pslot) / 64;
    ps    = m_en ? (int'(m_pslot) >> (2 * page)) % 4 : 0;
    ss    = EXP[ps] ? (int'(m_sub[ps]) >> (2 * page)) % 4 : 0;
    sm    = !mreq_n && rfrsh_n;
    owned = (addr == 16'hFFFF) && EXP[p3];
    sl = 4'hF; ex = 16'hFFFF;
    if (sm && !owned) begin
      sl[ps] = 1'b0;
      ex[4 * ps + ss] = 1'b0;
    end
    oe = sm && !rd_n && owned;
    dq = oe ? ~m_sub[p3] : 8'h00;
    cs[3] = !(page == 1 && !rd_n);
    cs[2] = !(page == 2 && !rd_n);
    cs[1] = !((page == 0 || page == 1) && !rd_n);
    cs[0] = !((page == 1 || page == 2) && !rd_n);
    return {sl, ex, cs, oe, dq, m_pslot};
  endfunction

  task automatic model_reset();
    m_pslot = 8'h00; m_en = 1'b0; m_pio = 1'b0; m_pmem = 1'b0;
    for (int i = 0; i < 4; i++) m_sub[i] = 8'h00;
  endtask

  // Register effects of the upcoming rising edge, given the inputs now on the bus
  task automatic model_clock();
    logic io, mw;
    int p3;
    io = !iorq_n && !wr_n && addr[7:0] == 8'hA8;
    mw = !mreq_n && rfrsh_n && !wr_n && addr == 16'hFFFF;
    p3 = int'(m_pslot) / 64;
    if (mw && !m_pmem && EXP[p3]) m_sub[p3] = din;
    if (io && !m_pio) begin
      m_pslot = din;
      m_en = 1'b1;
    end
    m_pio = io; m_pmem = mw;
  endtask

  task automatic check(input string name, input logic [40:0] act, input logic [40:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic [4:0] c);
    @(negedge clk);
    addr = a; din = d;
    {iorq_n, mreq_n, rfrsh_n, rd_n, wr_n} = c;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    addr = 16'h0000; din = 8'h00;
    {iorq_n, mreq_n, rfrsh_n, rd_n, wr_n} = IDLE;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [4:0] c;
    logic [15:0] a;
    reset = 1'b1;
    addr = 16'h0000; din = 8'h00;
    {iorq_n, mreq_n, rfrsh_n, rd_n, wr_n} = IDLE;

    vecs[0]  = mk(16'h0000, 8'h00, IDLE, 4'hF, 16'hFFFF, 4'hF,    1'b0, 8'h00, 8'h00);
    vecs[1]  = mk(16'h4000, 8'h00, MRD,  4'hE, 16'hFFFE, 4'b0100, 1'b0, 8'h00, 8'h00);
    vecs[2]  = mk(16'h00A8, 8'hC4, IOW,  4'hF, 16'hFFFF, 4'hF,    1'b0, 8'h00, 8'h00);
    vecs[3]  = mk(16'h00A8, 8'hC4, IOW,  4'hF, 16'hFFFF, 4'hF,    1'b0, 8'h00, 8'hC4);
    vecs[4]  = mk(16'h00A8, 8'h11, IOW,  4'hF, 16'hFFFF, 4'hF,    1'b0, 8'h00, 8'hC4);
    vecs[5]  = mk(16'h00A8, 8'h11, IOW,  4'hF, 16'hFFFF, 4'hF,    1'b0, 8'h00, 8'hC4);
    vecs[6]  = mk(16'h00A8, 8'h11, IOW,  4'hF, 16'hFFFF, 4'hF,    1'b0, 8'h00, 8'hC4);
    vecs[7]  = mk(16'h0000, 8'h00, IDLE, 4'hF, 16'hFFFF, 4'hF,    1'b0, 8'h00, 8'hC4);
    vecs[8]  = mk(16'h4000, 8'h00, MRD,  4'hD, 16'hFFEF, 4'b0100, 1'b0, 8'h00, 8'hC4);
    vecs[9]  = mk(16'hC000, 8'h00, MRD,  4'h7, 16'hEFFF, 4'hF,    1'b0, 8'h00, 8'hC4);
    vecs[10] = mk(16'h00A8, 8'hC0, IOW,  4'hF, 16'hFFFF, 4'hF,    1'b0, 8'h00, 8'hC4);
    vecs[11] = mk(16'h0000, 8'h00, IDLE, 4'hF, 16'hFFFF, 4'hF,    1'b0, 8'h00, 8'hC0);
    vecs[12] = mk(16'hFFFF, 8'h24, MWR,  4'hF, 16'hFFFF, 4'hF,    1'b0, 8'h00, 8'hC0);
    vecs[13] = mk(16'hFFFF, 8'h99, MWR,  4'hF, 16'hFFFF, 4'hF,    1'b0, 8'h00, 8'hC0);
    vecs[14] = mk(16'h0000, 8'h00, IDLE, 4'hF, 16'hFFFF, 4'hF,    1'b0, 8'h00, 8'hC0);
    vecs[15] = mk(16'hFFFF, 8'h00, MRD,  4'hF, 16'hFFFF, 4'hF,    1'b1, 8'hDB, 8'hC0);
    vecs[16] = mk(16'h8000, 8'h00, MRD,  4'hE, 16'hFFFE, 4'b1010, 1'b0, 8'h00, 8'hC0);
    vecs[17] = mk(16'h4000, 8'h00, MRD,  4'hE, 16'hFFFE, 4'b0100, 1'b0, 8'h00, 8'hC0);
    vecs[18] = mk(16'h00A8, 8'hC4, IOW,  4'hF, 16'hFFFF, 4'hF,    1'b0, 8'h00, 8'hC0);
    vecs[19] = mk(16'h4000, 8'h00, MRD,  4'hD, 16'hFFEF, 4'b0100, 1'b0, 8'h00, 8'hC4);
    vecs[20] = mk(16'h00A8, 8'hCC, IOW,  4'hF, 16'hFFFF, 4'hF,    1'b0, 8'h00, 8'hC4);
    vecs[21] = mk(16'h4000, 8'h00, MRD,  4'h7, 16'hDFFF, 4'b0100, 1'b0, 8'h00, 8'hCC);
    vecs[22] = mk(16'h00A8, 8'h55, IOW,  4'hF, 16'hFFFF, 4'hF,    1'b0, 8'h00, 8'hCC);
    vecs[23] = mk(16'hFFFF, 8'hFF, MWR,  4'hD, 16'hFFEF, 4'hF,    1'b0, 8'h00, 8'h55);
    vecs[24] = mk(16'hFFFF, 8'h00, MRD,  4'hD, 16'hFFEF, 4'hF,    1'b0, 8'h00, 8'h55);
    vecs[25] = mk(16'h00A8, 8'hC0, IOW,  4'hF, 16'hFFFF, 4'hF,    1'b0, 8'h00, 8'h55);
    vecs[26] = mk(16'hFFFF, 8'h00, MRD,  4'hF, 16'hFFFF, 4'hF,    1'b1, 8'hDB, 8'hC0);
    vecs[27] = mk(16'h8000, 8'h00, RFSH, 4'hF, 16'hFFFF, 4'hF,    1'b0, 8'h00, 8'hC0);
    vecs[28] = mk(16'h00A9, 8'h12, IOW,  4'hF, 16'hFFFF, 4'hF,    1'b0, 8'h00, 8'hC0);
    vecs[29] = mk(16'h0000, 8'h00, IDLE, 4'hF, 16'hFFFF, 4'hF,    1'b0, 8'h00, 8'hC0);

    // Outputs while reset is held
    @(negedge clk);
    #1;
    check("reset_state", obs, {4'hF, 16'hFFFF, 4'hF, 1'b0, 8'h00, 8'h00});
    do_reset();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].a, vecs[i].d, vecs[i].c);
      check($sformatf("vec%0d", i), obs, vecs[i].e);
    end

    // Reset asserted in the middle of a held A8h write of FFh
    drive(16'h00A8, 8'hFF, IOW);
    #1 reset = 1'b1;
    #1 check("rst_mid_write", {33'h0, pslot_q}, 41'h0);
    @(posedge clk);
    #1 check("rst_held", {33'h0, pslot_q}, 41'h0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("rst_released", {33'h0, pslot_q}, 41'h0);
    @(posedge clk);
    #1 check("rst_new_edge", {33'h0, pslot_q}, {33'h0, 8'hFF});
    drive(16'h4000, 8'h00, MRD);
    check("rst_enable", obs, {4'h7, 16'hEFFF, 4'b0100, 1'b0, 8'h00, 8'hFF});

    // Randomized bus traffic against the behavioural model
    do_reset();
    c = IDLE;
    a = 16'h0000;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 5))
          0: c = IDLE;
          1: c = MRD;
          2: c = MWR;
          3: c = IOW;
          4: c = RFSH;
          default: c = 5'($urandom);
        endcase
        case ($urandom_range(0, 3))
          0: a = {8'($urandom), 8'hA8};
          1: a = 16'hFFFF;
          2: a = {8'($urandom), 8'hA9};
          default: a = 16'($urandom);
        endcase
      end
      drive(a, 8'($urandom), c);
      check($sformatf("rand%0d", n), obs, model_out());
      model_clock();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msx_slot_expander.md
Name: msx_slot_expander

Overview:
- Parametrised MSX primary/secondary slot selector. Successor to the fixed 4-slot combinational mapper.
- Holds the primary slot register (I/O port A8h) internally and one secondary-slot register per expanded primary slot (memory address FFFFh).
- Decodes slot selects, subslot selects and the page chip-selects for the cartridge/ROM fabric.
- Sits between the Z80 bus and the slot devices (RAM, BIOS, cartridges).

Parameters:
- EXPANDED, 4'b1000, bit i = 1 makes primary slot i expanded (has an FFFFh subslot register).
- PSLOT_PORT, 8'hA8, I/O address of the primary slot register.
- BOOT_GATE, 1, 1 = force slot 0-0 on all pages until the first primary-slot write; 0 = use register contents immediately.

Ports:
- clk  in  1  system clock, all state sampled on rising edge
- reset  in  1  reset, asynchronous, active-high
- addr  in  16  CPU address
- din  in  8  CPU write data
- iorq_n  in  1  Z80 IORQ
- mreq_n  in  1  Z80 MREQ
- rfrsh_n  in  1  Z80 RFSH
- rd_n  in  1  Z80 RD
- wr_n  in  1  Z80 WR
- dout  out  8  readback data (inverted subslot register)
- dout_oe  out  1  dout valid, drive onto CPU bus
- pslot_q  out  8  primary slot register contents (for PPI port A readback)
- sltsl_n  out  4  primary slot selects, active-low
- exp_sltsl_n  out  16  slot/subslot selects, index 4*slot+sub, active-low
- cs1_n  out  1  page 1 (4000h-7FFFh) read select
- cs2_n  out  1  page 2 (8000h-BFFFh) read select
- cs01_n  out  1  page 0 or 1 read
- cs12_n  out  1  page 1 or 2 read

Behaviour:
- State: pslot[7:0], sub[s][7:0] for each s with EXPANDED[s]=1, enable, iowr_d, memwr_d (previous-cycle strobe samples).
- Reset (async): pslot=0, all sub=0, enable=0, iowr_d=memwr_d=0.
- Outputs at reset: sltsl_n=4'hF, exp_sltsl_n=16'hFFFF, dout_oe=0, dout=8'h00, pslot_q=0.
- Strobes:
  - iowr = ~iorq_n & ~wr_n & addr[7:0]==PSLOT_PORT.
  - selmem = ~mreq_n & rfrsh_n.
  - memwr = selmem & ~wr_n & addr==16'hFFFF.
- Writes are edge-qualified: a register updates only on the first clk where its strobe is 1 and the delayed copy is 0. This gives exactly one update per bus cycle regardless of strobe length. Latency: new value visible in decode 1 clk after the qualifying edge.
- Primary write: pslot<=din; enable<=1 (sticky until reset).
- Secondary write: only when EXPANDED[p3]=1, where p3=pslot[7:6] (value before any same-cycle update); sub[p3]<=din. If p3 is not expanded, FFFFh is ordinary memory and no register changes.
- Page decode:
  - page = addr[15:14].
  - ps = (BOOT_GATE & ~enable) ? 0 : pslot[2*page+1:2*page].
  - ss = EXPANDED[ps] ? sub[ps][2*page+1:2*page] : 0.
- Slot selects:
  - sltsl_n[ps]=0 when selmem, except during an FFFFh access while EXPANDED[p3]=1. In that case all sltsl_n and exp_sltsl_n are 1, because the expander owns the cycle.
  - exp_sltsl_n[4*ps+ss] = sltsl_n[ps]; all other bits are 1.
  - Non-expanded slots only ever assert the sub=0 bit.
- Readback: addr==FFFFh & selmem & ~rd_n & EXPANDED[p3] gives dout=~sub[p3], dout_oe=1. Otherwise dout_oe=0 and dout=0. Combinational.
- Page chip-selects: csN_n = ~(page==N & ~rd_n). cs01_n = cs0_n & cs1_n; cs12_n = cs1_n & cs2_n. Not gated by mreq (matches existing ROM interface).
- Simultaneous iowr and memwr (illegal on Z80): both are applied; the secondary write indexes with the old pslot.
- Async reset mid-write: the register returns to its reset value; the strobe still high after release is treated as a new edge (the delayed copy is 0).
- pslot_q = pslot, ungated by enable.

Test Plan:
- Reset, then memory read at 4000h with pslot never written (BOOT_GATE=1) -> sltsl_n=4'b1110, exp_sltsl_n[0]=0, cs1_n=0.
- IO write A8h=8'hC4 held 5 clk -> pslot_q=C4 after 1 clk, one update only. Read 4000h -> sltsl_n[1]=0. Read C000h -> sltsl_n[3]=0.
- With pslot=C0, EXPANDED=1000: write FFFFh=8'h24 -> no sltsl asserted during the write. Read FFFFh -> dout=8'hDB, dout_oe=1. Read 4000h (page1 slot0) unaffected. Set pslot=C4, read 4000h -> exp_sltsl_n[4*1+0]=0.
- pslot=55 (page3 slot1, not expanded), write FFFFh=8'hFF -> sltsl_n[1]=0, sub registers unchanged, dout_oe=0 on readback.
- Refresh cycle (mreq_n=0, rfrsh_n=0) at 8000h -> all selects high. I/O write to port A9h -> pslot unchanged.
- Assert reset while iorq_n/wr_n held low on A8h with din=FF -> pslot=0 during reset; pslot=FF 1 clk after release; enable=1.
